axi_lite_demux: RTL and testbench
=================================

# axi_lite_demux

Parametrised 1-to-N AXI-Lite address demultiplexer: one upstream master port fans out to NUM_SLAVES downstream slave ports, each owning a contiguous window of 2^SLAVE_ADDR_BITS bytes starting at BASE_ADDR. It replaces point-to-point AXI-Lite wiring between the CPU-side master and the Ethernet register blocks (MAC, DMA, MDIO and similar). It adds decode errors for unmapped addresses, an rresp channel, and independent concurrent read and write paths.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width of all ports
- DATA_WIDTH, 32, data width of all ports
- NUM_SLAVES, 4, number of downstream ports, 1..16
- SLAVE_ADDR_BITS, 12, log2 of the window size per slave
- BASE_ADDR, 32'h4000_0000, base of slave 0; must be aligned to 2^SLAVE_ADDR_BITS
- TIMEOUT_CYCLES, 256, response timeout; only used with AXI_DEMUX_TIMEOUT_EN

Ports:
- Clocking and reset: one clock, aclk; reset is asynchronous and active-high, named areset.
- aclk  in  1  clock
- areset  in  1  asynchronous active-high reset
- s_awaddr/s_awvalid/s_awready  in/in/out  ADDR_WIDTH/1/1  upstream write address
- s_wdata/s_wlast/s_wvalid/s_wready  in/in/in/out  DATA_WIDTH/1/1/1  upstream write data; wlast ignored
- s_bresp/s_bvalid/s_bready  out/out/in  2/1/1  upstream write response
- s_araddr/s_arvalid/s_arready  in/in/out  ADDR_WIDTH/1/1  upstream read address
- s_rdata/s_rresp/s_rlast/s_rvalid/s_rready  out/out/out/out/in  DATA_WIDTH/2/1/1/1  upstream read data
- m_awaddr, m_araddr  out  NUM_SLAVES*ADDR_WIDTH  per-slave addresses, full address forwarded
- m_wdata  out  NUM_SLAVES*DATA_WIDTH; m_rdata  in  NUM_SLAVES*DATA_WIDTH
- m_awvalid, m_wvalid, m_wlast, m_bready, m_arvalid, m_rready  out  NUM_SLAVES  per-slave controls
- m_awready, m_wready, m_bvalid, m_arready, m_rvalid  in  NUM_SLAVES
- m_bresp, m_rresp  in  NUM_SLAVES*2

## Operation
- Decode: idx = (addr - BASE_ADDR) >> SLAVE_ADDR_BITS. The address is mapped iff addr >= BASE_ADDR and idx < NUM_SLAVES. The comparison is unsigned and evaluated at full ADDR_WIDTH.
- Write FSM states:
  - W_IDLE: s_awready = s_wready = s_awvalid && s_wvalid (combinational). On accept, register addr, data and idx. Go to W_FWD if mapped, else W_ERR.
  - W_FWD: m_awvalid[idx] and m_wvalid[idx] are held independently, each dropping after its own ready. m_wlast[idx]=1. Go to W_RESP once both have handshaken.
  - W_RESP: m_bready[idx]=1. On m_bvalid[idx], capture m_bresp into s_bresp, set s_bvalid, go to W_OUT.
  - W_ERR: s_bvalid=1, s_bresp=2'b11 (DECERR), go to W_OUT.
  - W_OUT: hold s_bvalid and s_bresp until s_bready, then return to W_IDLE.
- Read FSM mirrors the write FSM: R_IDLE (s_arready = s_arvalid), R_FWD, R_RESP, R_ERR, R_OUT.
  - Response captures m_rdata and m_rresp.
  - R_ERR returns rdata=0 and rresp=2'b11.
  - s_rlast = s_rvalid.
- Read and write FSMs are fully independent and may target the same slave concurrently.
- Only one outstanding transaction per direction.
- Non-selected m_* valids and readies are 0. m_*addr and m_wdata are broadcast to all slaves.

## Timing
- Reset values: all *valid and *ready outputs 0, s_bresp=0, s_rresp=0, s_rdata=0, s_rlast=0. Both FSMs in IDLE.
- Reset asserted mid-transaction: all valids drop immediately, no response is issued, and any pending transaction is discarded.
- Mapped write, accepted at cycle 0:
  - m_awvalid and m_wvalid high from cycle 1.
  - With slave ready and m_bvalid both at cycle 1, s_bvalid is high at cycle 2.
- Unmapped access accepted at cycle 0: s_bvalid or s_rvalid high at cycle 1.
- s_*valid is registered and stable until the handshake. Upstream valid without ready is never dropped by the block.
- The upstream write path stalls (s_awready=0) while s_awvalid is high and s_wvalid is low.

## Configuration
- AXI_DEMUX_TIMEOUT_EN defined:
  - A 16-bit counter runs in *_FWD and *_RESP states.
  - When it reaches TIMEOUT_CYCLES, the block deasserts all m_* controls for that direction.
  - It then responds upstream with resp=2'b10 (SLVERR) and rdata=0.
  - The counter clears on every state entry.
- Not defined: no counter; the block waits indefinitely on the slave.

## Test plan
- Write 0x4000_2010 data 0xDEAD_BEEF, slave 2 bresp=OKAY -> m_awvalid=4'b0100 with m_wdata=0xDEAD_BEEF; then s_bresp=2'b00, s_bvalid at cycle 2 with zero-wait slave.
- Read 0x4000_3FFC, slave 3 returns 0x1234_5678 with rresp=OKAY -> s_rdata=0x1234_5678, s_rresp=0, s_rlast=1.
- Read 0x4000_4000 and write 0x3FFF_FFFC -> DECERR (2'b11) at cycle 1, no m_* valid asserted, rdata=0.
- Concurrent write to slave 1 and read from slave 1 issued the same cycle -> both complete; responses are independent and neither blocks the other.
- s_bready held low for 5 cycles -> s_bvalid and s_bresp stable; new s_awvalid not accepted until the handshake.
- With AXI_DEMUX_TIMEOUT_EN and TIMEOUT_CYCLES=16, slave 0 never asserts bvalid -> SLVERR 2'b10 after 16 cycles in W_RESP. Additionally, areset pulsed mid-W_FWD -> all outputs return to 0.

Source files
------------

// File: rtl/axi_lite_demux_if.sv
// Signal bundle for the 1-to-N AXI-Lite demux: the upstream s_* port plus the
// flattened per-slave m_* vectors. 'slave' is the demux view, 'master' the environment view.
`timescale 1ns/1ps
interface axi_lite_demux_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLAVES = 4
);
    logic [ADDR_WIDTH-1:0]            s_awaddr;
    logic                             s_awvalid;
    logic                             s_awready;
    logic [DATA_WIDTH-1:0]            s_wdata;
    logic                             s_wlast;
    logic                             s_wvalid;
    logic                             s_wready;
    logic [1:0]                       s_bresp;
    logic                             s_bvalid;
    logic                             s_bready;
    logic [ADDR_WIDTH-1:0]            s_araddr;
    logic                             s_arvalid;
    logic                             s_arready;
    logic [DATA_WIDTH-1:0]            s_rdata;
    logic [1:0]                       s_rresp;
    logic                             s_rlast;
    logic                             s_rvalid;
    logic                             s_rready;

    logic [NUM_SLAVES*ADDR_WIDTH-1:0] m_awaddr;
    logic [NUM_SLAVES*ADDR_WIDTH-1:0] m_araddr;
    logic [NUM_SLAVES*DATA_WIDTH-1:0] m_wdata;
    logic [NUM_SLAVES*DATA_WIDTH-1:0] m_rdata;
    logic [NUM_SLAVES-1:0]            m_awvalid;
    logic [NUM_SLAVES-1:0]            m_wvalid;
    logic [NUM_SLAVES-1:0]            m_wlast;
    logic [NUM_SLAVES-1:0]            m_bready;
    logic [NUM_SLAVES-1:0]            m_arvalid;
    logic [NUM_SLAVES-1:0]            m_rready;
    logic [NUM_SLAVES-1:0]            m_awready;
    logic [NUM_SLAVES-1:0]            m_wready;
    logic [NUM_SLAVES-1:0]            m_bvalid;
    logic [NUM_SLAVES-1:0]            m_arready;
    logic [NUM_SLAVES-1:0]            m_rvalid;
    logic [NUM_SLAVES*2-1:0]          m_bresp;
    logic [NUM_SLAVES*2-1:0]          m_rresp;

    modport slave (
        input  s_awaddr, s_awvalid, s_wdata, s_wlast, s_wvalid, s_bready,
               s_araddr, s_arvalid, s_rready,
        output s_awready, s_wready, s_bresp, s_bvalid,
               s_arready, s_rdata, s_rresp, s_rlast, s_rvalid,
        output m_awaddr, m_araddr, m_wdata, m_awvalid, m_wvalid, m_wlast,
               m_bready, m_arvalid, m_rready,
        input  m_rdata, m_awready, m_wready, m_bvalid, m_arready, m_rvalid,
               m_bresp, m_rresp
    );

    modport master (
        output s_awaddr, s_awvalid, s_wdata, s_wlast, s_wvalid, s_bready,
               s_araddr, s_arvalid, s_rready,
        input  s_awready, s_wready, s_bresp, s_bvalid,
               s_arready, s_rdata, s_rresp, s_rlast, s_rvalid,
        input  m_awaddr, m_araddr, m_wdata, m_awvalid, m_wvalid, m_wlast,
               m_bready, m_arvalid, m_rready,
        output m_rdata, m_awready, m_wready, m_bvalid, m_arready, m_rvalid,
               m_bresp, m_rresp
    );
endinterface

// File: rtl/axi_lite_demux.sv
// 1-to-N AXI-Lite address demux with independent read/write FSMs and DECERR for holes.
// Optional response timeout (SLVERR) enabled by defining AXI_DEMUX_TIMEOUT_EN.
`timescale 1ns/1ps
module axi_lite_demux #(
    parameter int                    ADDR_WIDTH      = 32,
    parameter int                    DATA_WIDTH      = 32,
    parameter int                    NUM_SLAVES      = 4,
    parameter int                    SLAVE_ADDR_BITS = 12,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = 'h4000_0000,
    parameter int                    TIMEOUT_CYCLES  = 256
) (
    input  logic              aclk,
    input  logic              areset,
    axi_lite_demux_if.slave   bus
);
    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    typedef enum logic [2:0] {W_IDLE, W_FWD, W_RESP, W_ERR, W_OUT} wstate_t;
    typedef enum logic [2:0] {R_IDLE, R_FWD, R_RESP, R_ERR, R_OUT} rstate_t;

    function automatic logic addr_hit(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] slot;
        slot = (addr - BASE_ADDR) >> SLAVE_ADDR_BITS;
        return (addr >= BASE_ADDR) && (slot < ADDR_WIDTH'(NUM_SLAVES));
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] slot;
        slot = (addr - BASE_ADDR) >> SLAVE_ADDR_BITS;
        return slot[IDX_W-1:0];
    endfunction

    wstate_t               wstate_q, wstate_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [IDX_W-1:0]      widx_q, widx_d;
    logic                  aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;

    rstate_t               rstate_q, rstate_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [IDX_W-1:0]      ridx_q, ridx_d;
    logic                  ar_done_q, ar_done_d;
    logic                  rvalid_q, rvalid_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic                  w_accept, r_accept, w_to, r_to;
    logic                  aw_fin, w_fin, ar_fin;
    logic [NUM_SLAVES-1:0] m_awvalid_c, m_wvalid_c, m_wlast_c, m_bready_c;
    logic [NUM_SLAVES-1:0] m_arvalid_c, m_rready_c;
    logic [1:0]            m_bresp_a [NUM_SLAVES];
    logic [1:0]            m_rresp_a [NUM_SLAVES];
    logic [DATA_WIDTH-1:0] m_rdata_a [NUM_SLAVES];
    logic                  unused_sig;

    // Addresses and write data are broadcast; only the valids select a slave.
    for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_slave
        assign bus.m_awaddr[gi*ADDR_WIDTH +: ADDR_WIDTH] = awaddr_q;
        assign bus.m_araddr[gi*ADDR_WIDTH +: ADDR_WIDTH] = araddr_q;
        assign bus.m_wdata[gi*DATA_WIDTH +: DATA_WIDTH]  = wdata_q;
        assign m_bresp_a[gi] = bus.m_bresp[gi*2 +: 2];
        assign m_rresp_a[gi] = bus.m_rresp[gi*2 +: 2];
        assign m_rdata_a[gi] = bus.m_rdata[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    assign w_accept      = (wstate_q == W_IDLE) && bus.s_awvalid && bus.s_wvalid;
    assign r_accept      = (rstate_q == R_IDLE) && bus.s_arvalid;
    assign bus.s_awready = w_accept;
    assign bus.s_wready  = w_accept;
    assign bus.s_arready = r_accept;
    assign bus.s_bvalid  = bvalid_q;
    assign bus.s_bresp   = bresp_q;
    assign bus.s_rvalid  = rvalid_q;
    assign bus.s_rresp   = rresp_q;
    assign bus.s_rdata   = rdata_q;
    assign bus.s_rlast   = rvalid_q;
    assign bus.m_awvalid = m_awvalid_c;
    assign bus.m_wvalid  = m_wvalid_c;
    assign bus.m_wlast   = m_wlast_c;
    assign bus.m_bready  = m_bready_c;
    assign bus.m_arvalid = m_arvalid_c;
    assign bus.m_rready  = m_rready_c;

`ifdef AXI_DEMUX_TIMEOUT_EN
    logic [15:0] wcnt_q, rcnt_q;

    // Counters restart on every state change so each phase gets the full budget.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wcnt_q <= '0;
            rcnt_q <= '0;
        end else begin
            if (wstate_d != wstate_q)
                wcnt_q <= '0;
            else if (wstate_q == W_FWD || wstate_q == W_RESP)
                wcnt_q <= wcnt_q + 16'd1;
            if (rstate_d != rstate_q)
                rcnt_q <= '0;
            else if (rstate_q == R_FWD || rstate_q == R_RESP)
                rcnt_q <= rcnt_q + 16'd1;
        end
    end

    assign w_to = (wstate_q == W_FWD || wstate_q == W_RESP) && (wcnt_q >= 16'(TIMEOUT_CYCLES));
    assign r_to = (rstate_q == R_FWD || rstate_q == R_RESP) && (rcnt_q >= 16'(TIMEOUT_CYCLES));
    assign unused_sig = bus.s_wlast;
`else
    assign w_to = 1'b0;
    assign r_to = 1'b0;
    assign unused_sig = bus.s_wlast ^ (^32'(TIMEOUT_CYCLES));
`endif

    assign aw_fin = aw_done_q | bus.m_awready[widx_q];
    assign w_fin  = w_done_q  | bus.m_wready[widx_q];
    assign ar_fin = ar_done_q | bus.m_arready[ridx_q];

    always_comb begin
        wstate_d    = wstate_q;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        widx_d      = widx_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        bvalid_d    = bvalid_q;
        bresp_d     = bresp_q;
        m_awvalid_c = '0;
        m_wvalid_c  = '0;
        m_wlast_c   = '0;
        m_bready_c  = '0;
        case (wstate_q)
            W_IDLE: if (w_accept) begin
                awaddr_d  = bus.s_awaddr;
                wdata_d   = bus.s_wdata;
                widx_d    = addr_idx(bus.s_awaddr);
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                if (addr_hit(bus.s_awaddr)) begin
                    wstate_d = W_FWD;
                end else begin
                    wstate_d = W_ERR;
                    bvalid_d = 1'b1;
                    bresp_d  = 2'b11;
                end
            end
            W_FWD: if (w_to) begin
                wstate_d = W_OUT;
                bvalid_d = 1'b1;
                bresp_d  = 2'b10;
            end else begin
                m_awvalid_c[widx_q] = ~aw_done_q;
                m_wvalid_c[widx_q]  = ~w_done_q;
                m_wlast_c[widx_q]   = 1'b1;
                aw_done_d = aw_fin;
                w_done_d  = w_fin;
                // A zero-wait slave may answer in the same cycle both handshakes finish.
                if (aw_fin && w_fin) begin
                    m_bready_c[widx_q] = 1'b1;
                    if (bus.m_bvalid[widx_q]) begin
                        wstate_d = W_OUT;
                        bvalid_d = 1'b1;
                        bresp_d  = m_bresp_a[widx_q];
                    end else begin
                        wstate_d = W_RESP;
                    end
                end
            end
            W_RESP: if (w_to) begin
                wstate_d = W_OUT;
                bvalid_d = 1'b1;
                bresp_d  = 2'b10;
            end else begin
                m_bready_c[widx_q] = 1'b1;
                if (bus.m_bvalid[widx_q]) begin
                    wstate_d = W_OUT;
                    bvalid_d = 1'b1;
                    bresp_d  = m_bresp_a[widx_q];
                end
            end
            W_ERR, W_OUT: begin
                if (bus.s_bready) begin
                    wstate_d = W_IDLE;
                    bvalid_d = 1'b0;
                end else begin
                    wstate_d = W_OUT;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    always_comb begin
        rstate_d    = rstate_q;
        araddr_d    = araddr_q;
        ridx_d      = ridx_q;
        ar_done_d   = ar_done_q;
        rvalid_d    = rvalid_q;
        rresp_d     = rresp_q;
        rdata_d     = rdata_q;
        m_arvalid_c = '0;
        m_rready_c  = '0;
        case (rstate_q)
            R_IDLE: if (r_accept) begin
                araddr_d  = bus.s_araddr;
                ridx_d    = addr_idx(bus.s_araddr);
                ar_done_d = 1'b0;
                if (addr_hit(bus.s_araddr)) begin
                    rstate_d = R_FWD;
                end else begin
                    rstate_d = R_ERR;
                    rvalid_d = 1'b1;
                    rresp_d  = 2'b11;
                    rdata_d  = '0;
                end
            end
            R_FWD: if (r_to) begin
                rstate_d = R_OUT;
                rvalid_d = 1'b1;
                rresp_d  = 2'b10;
                rdata_d  = '0;
            end else begin
                m_arvalid_c[ridx_q] = ~ar_done_q;
                ar_done_d = ar_fin;
                if (ar_fin) begin
                    m_rready_c[ridx_q] = 1'b1;
                    if (bus.m_rvalid[ridx_q]) begin
                        rstate_d = R_OUT;
                        rvalid_d = 1'b1;
                        rresp_d  = m_rresp_a[ridx_q];
                        rdata_d  = m_rdata_a[ridx_q];
                    end else begin
                        rstate_d = R_RESP;
                    end
                end
            end
            R_RESP: if (r_to) begin
                rstate_d = R_OUT;
                rvalid_d = 1'b1;
                rresp_d  = 2'b10;
                rdata_d  = '0;
            end else begin
                m_rready_c[ridx_q] = 1'b1;
                if (bus.m_rvalid[ridx_q]) begin
                    rstate_d = R_OUT;
                    rvalid_d = 1'b1;
                    rresp_d  = m_rresp_a[ridx_q];
                    rdata_d  = m_rdata_a[ridx_q];
                end
            end
            R_ERR, R_OUT: begin
                if (bus.s_rready) begin
                    rstate_d = R_IDLE;
                    rvalid_d = 1'b0;
                end else begin
                    rstate_d = R_OUT;
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wstate_q  <= W_IDLE;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            widx_q    <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            rstate_q  <= R_IDLE;
            araddr_q  <= '0;
            ridx_q    <= '0;
            ar_done_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= 2'b00;
            rdata_q   <= '0;
        end else begin
            wstate_q  <= wstate_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            widx_q    <= widx_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rstate_q  <= rstate_d;
            araddr_q  <= araddr_d;
            ridx_q    <= ridx_d;
            ar_done_q <= ar_done_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
        end
    end
endmodule

// File: tb/tb_axi_lite_demux.sv
// Directed bench for axi_lite_demux: decode, zero-wait forwarding, DECERR, concurrency,
// upstream backpressure, async reset mid-transaction and (when enabled) the timeout.
`timescale 1ns/1ps
module tb_axi_lite_demux;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NS = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_lite_demux_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS)) bus ();

    axi_lite_demux #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS), .SLAVE_ADDR_BITS(12),
        .BASE_ADDR(32'h4000_0000), .TIMEOUT_CYCLES(16)
    ) dut (
        .aclk  (clk),
        .areset(rst),
        .bus   (bus)
    );

    // Zero-wait slave stubs, shaped per test through these registers.
    logic [NS-1:0]    sl_ready, sl_bvalid, sl_rvalid;
    logic [2*NS-1:0]  sl_bresp, sl_rresp;
    logic [NS*DW-1:0] sl_rdata;
    assign bus.m_awready = sl_ready;
    assign bus.m_wready  = sl_ready;
    assign bus.m_arready = sl_ready;
    assign bus.m_bvalid  = sl_bvalid;
    assign bus.m_rvalid  = sl_rvalid;
    assign bus.m_bresp   = sl_bresp;
    assign bus.m_rresp   = sl_rresp;
    assign bus.m_rdata   = sl_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_accept(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.s_awaddr  = a;
        bus.s_wdata   = d;
        bus.s_awvalid = 1'b1;
        bus.s_wvalid  = 1'b1;
        #1 check("s_awready", bus.s_awready, 1'b1);
        tick();
        bus.s_awvalid = 1'b0;
        bus.s_wvalid  = 1'b0;
    endtask

    task automatic read_accept(input logic [31:0] a);
        @(negedge clk);
        bus.s_araddr  = a;
        bus.s_arvalid = 1'b1;
        #1 check("s_arready", bus.s_arready, 1'b1);
        tick();
        bus.s_arvalid = 1'b0;
    endtask

    task automatic b_handshake();
        @(negedge clk);
        bus.s_bready = 1'b1;
        tick();
        bus.s_bready = 1'b0;
    endtask

    task automatic r_handshake();
        @(negedge clk);
        bus.s_rready = 1'b1;
        tick();
        bus.s_rready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.s_awaddr = '0; bus.s_awvalid = 1'b0; bus.s_wdata = '0; bus.s_wlast = 1'b1;
        bus.s_wvalid = 1'b0; bus.s_bready = 1'b0; bus.s_araddr = '0; bus.s_arvalid = 1'b0;
        bus.s_rready = 1'b0;
        sl_ready  = '1;
        sl_bvalid = '1;
        sl_rvalid = '1;
        sl_bresp  = '0;
        sl_rresp  = '0;
        sl_rdata  = {32'h1234_5678, 32'h0000_2222, 32'hA1A1_0001, 32'h0000_0000};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_s_bvalid",  bus.s_bvalid, 1'b0);
        check("rst_s_rvalid",  bus.s_rvalid, 1'b0);
        check("rst_s_bresp",   bus.s_bresp, 2'b00);
        check("rst_s_rresp",   bus.s_rresp, 2'b00);
        check("rst_s_rdata",   bus.s_rdata, 32'h0);
        check("rst_s_rlast",   bus.s_rlast, 1'b0);
        check("rst_m_awvalid", bus.m_awvalid, 4'b0000);
        check("rst_m_arvalid", bus.m_arvalid, 4'b0000);
        check("rst_m_bready",  bus.m_bready, 4'b0000);
        @(negedge clk);
        rst = 1'b0;

        // Mapped write to slave 2, zero-wait slave
        write_accept(32'h4000_2010, 32'hDEAD_BEEF);
        check("w1_m_awvalid", bus.m_awvalid, 4'b0100);
        check("w1_m_wvalid",  bus.m_wvalid, 4'b0100);
        check("w1_m_wlast",   bus.m_wlast, 4'b0100);
        check("w1_m_wdata",   bus.m_wdata[2*DW +: DW], 32'hDEAD_BEEF);
        check("w1_m_awaddr",  bus.m_awaddr[2*AW +: AW], 32'h4000_2010);
        check("w1_s_bvalid_c1", bus.s_bvalid, 1'b0);
        tick();
        check("w1_s_bvalid_c2", bus.s_bvalid, 1'b1);
        check("w1_s_bresp",   bus.s_bresp, 2'b00);
        check("w1_m_awvalid_done", bus.m_awvalid, 4'b0000);
        b_handshake();
        check("w1_s_bvalid_after", bus.s_bvalid, 1'b0);

        // Mapped read from slave 3
        read_accept(32'h4000_3FFC);
        check("r1_m_arvalid", bus.m_arvalid, 4'b1000);
        check("r1_m_araddr",  bus.m_araddr[3*AW +: AW], 32'h4000_3FFC);
        tick();
        check("r1_s_rvalid", bus.s_rvalid, 1'b1);
        check("r1_s_rdata",  bus.s_rdata, 32'h1234_5678);
        check("r1_s_rresp",  bus.s_rresp, 2'b00);
        check("r1_s_rlast",  bus.s_rlast, 1'b1);
        r_handshake();
        check("r1_s_rvalid_after", bus.s_rvalid, 1'b0);
        check("r1_s_rlast_after",  bus.s_rlast, 1'b0);

        // Unmapped read just past the last window, then unmapped write below base
        read_accept(32'h4000_4000);
        check("r2_s_rvalid_c1", bus.s_rvalid, 1'b1);
        check("r2_s_rresp",   bus.s_rresp, 2'b11);
        check("r2_s_rdata",   bus.s_rdata, 32'h0);
        check("r2_m_arvalid", bus.m_arvalid, 4'b0000);
        r_handshake();
        write_accept(32'h3FFF_FFFC, 32'h1111_1111);
        check("w2_s_bvalid_c1", bus.s_bvalid, 1'b1);
        check("w2_s_bresp",   bus.s_bresp, 2'b11);
        check("w2_m_awvalid", bus.m_awvalid, 4'b0000);
        check("w2_m_wvalid",  bus.m_wvalid, 4'b0000);
        b_handshake();

        // Concurrent write and read to slave 1
        sl_bresp = 8'b00_00_01_00;
        @(negedge clk);
        bus.s_awaddr = 32'h4000_1000; bus.s_wdata = 32'hCAFE_0001;
        bus.s_awvalid = 1'b1; bus.s_wvalid = 1'b1;
        bus.s_araddr = 32'h4000_1004; bus.s_arvalid = 1'b1;
        #1;
        check("c_s_awready", bus.s_awready, 1'b1);
        check("c_s_arready", bus.s_arready, 1'b1);
        tick();
        bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0; bus.s_arvalid = 1'b0;
        check("c_m_awvalid", bus.m_awvalid, 4'b0010);
        check("c_m_arvalid", bus.m_arvalid, 4'b0010);
        tick();
        check("c_s_bvalid", bus.s_bvalid, 1'b1);
        check("c_s_bresp",  bus.s_bresp, 2'b01);
        check("c_s_rvalid", bus.s_rvalid, 1'b1);
        check("c_s_rdata",  bus.s_rdata, 32'hA1A1_0001);
        b_handshake();
        check("c_s_bvalid_after", bus.s_bvalid, 1'b0);
        check("c_s_rvalid_held",  bus.s_rvalid, 1'b1);
        r_handshake();
        check("c_s_rvalid_after", bus.s_rvalid, 1'b0);

        // Upstream backpressure: response held, next write stalled
        sl_bresp = 8'b00_00_01_10;
        write_accept(32'h4000_0004, 32'h0000_0055);
        tick();
        check("bp_s_bvalid", bus.s_bvalid, 1'b1);
        @(negedge clk);
        bus.s_awaddr = 32'h4000_1008; bus.s_wdata = 32'h0000_0077;
        bus.s_awvalid = 1'b1; bus.s_wvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("bp_hold%0d_bvalid", i), bus.s_bvalid, 1'b1);
            check($sformatf("bp_hold%0d_bresp", i), bus.s_bresp, 2'b10);
            check($sformatf("bp_hold%0d_awready", i), bus.s_awready, 1'b0);
        end
        @(negedge clk);
        bus.s_bready = 1'b1;
        tick();
        bus.s_bready = 1'b0;
        check("bp_s_bvalid_after", bus.s_bvalid, 1'b0);
        check("bp_s_awready_idle", bus.s_awready, 1'b1);
        tick();
        bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
        check("bp_next_m_awvalid", bus.m_awvalid, 4'b0010);
        check("bp_next_m_wdata",   bus.m_wdata[1*DW +: DW], 32'h0000_0077);
        tick();
        check("bp_next_s_bvalid", bus.s_bvalid, 1'b1);
        check("bp_next_s_bresp",  bus.s_bresp, 2'b01);
        b_handshake();

        // Slave never ready: valids held, then async reset discards the write
        sl_ready = '0;
        write_accept(32'h4000_0100, 32'h0000_0099);
        check("st_m_awvalid", bus.m_awvalid, 4'b0001);
        check("st_m_wvalid",  bus.m_wvalid, 4'b0001);
        repeat (3) tick();
        check("st_m_awvalid_held", bus.m_awvalid, 4'b0001);
        check("st_s_bvalid", bus.s_bvalid, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("ar_m_awvalid", bus.m_awvalid, 4'b0000);
        check("ar_m_wvalid",  bus.m_wvalid, 4'b0000);
        check("ar_s_bvalid",  bus.s_bvalid, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        sl_ready = '1;
        repeat (3) tick();
        check("ar_s_bvalid_later",  bus.s_bvalid, 1'b0);
        check("ar_m_awvalid_later", bus.m_awvalid, 4'b0000);

`ifdef AXI_DEMUX_TIMEOUT_EN
        // Slave 0 never responds: SLVERR after 16 cycles in W_RESP
        begin
            int cyc;
            sl_bvalid = '0;
            write_accept(32'h4000_0000, 32'h0000_0001);
            cyc = 1;
            while (!bus.s_bvalid && cyc < 100) begin
                tick();
                cyc++;
            end
            check("to_cycle",    cyc, 19);
            check("to_s_bresp",  bus.s_bresp, 2'b10);
            check("to_m_bready", bus.m_bready, 4'b0000);
            b_handshake();
            sl_bvalid = '1;
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
